noc_packetizer: RTL and testbench
=================================

# noc_packetizer

Core-side network interface transmitter. Turns a core transfer request (destination coordinates, payload length) plus an AXI-Stream payload into a routable NoC packet: one header flit, then up to MAX_PACKAGES payload flits, with tlast on the final flit. The output drives the router's local (core, index 0) input port. It produces exactly the header fields the router's XY routing decision decodes.

## Interface
Parameters:
- DATA_WIDTH, 32, flit width; must be ≥ 4*CS + LEN_W.
- CS, 2, width of one coordinate.
- MAX_PACKAGES, 4, maximum payload flits per packet.
- router_X, 0, X coordinate of the attached router (source X).
- router_Y, 0, Y coordinate of the attached router (source Y).

Ports (LEN_W = $clog2(MAX_PACKAGES)+1):
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  transfer request valid.
- req_ready  out  1  request accepted when both valid and ready are high.
- req_dest_x  in  CS  destination X.
- req_dest_y  in  CS  destination Y.
- req_len  in  LEN_W  payload flit count.
- len_err  out  1  sticky flag: a request had req_len > MAX_PACKAGES; cleared only by rst.
- in  axis_if.s  DATA_WIDTH  payload from the core (tdata, tvalid, tready; tlast ignored).
- out  axis_if.m  DATA_WIDTH  packet flits to the router (tdata, tvalid, tready, tlast).

## Operation
- Header layout: tdata[CS-1:0]=dest X; [2CS-1:CS]=dest Y; [3CS-1:2CS]=source X; [4CS-1:3CS]=source Y; [4CS+LEN_W-1:4CS]=length; all other bits 0.
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE: req_ready=1. On handshake, latch dest and length, then go to HEADER. If req_len > MAX_PACKAGES, use MAX_PACKAGES as the length and set len_err.
- HEADER: load the header into the output register when it is free. If the length is 0, set tlast=1 on the header and return to IDLE. Otherwise go to PAYLOAD with remaining = length.
- PAYLOAD: in.tready = (!out.tvalid | out.tready). Each input handshake loads the output register and decrements remaining. The flit that brings remaining to 0 carries tlast=1 and returns the FSM to IDLE.
- Output register: while out.tvalid & !out.tready, tdata and tlast are held stable and no new flit is loaded.
- Arithmetic: the remaining counter is LEN_W bits and never wraps below 0.

## Timing
- Reset values: out.tvalid=0, out.tdata=0, out.tlast=0, in.tready=0, req_ready=0 while rst is high, len_err=0, state=IDLE.
- Request accepted at cycle N gives header out.tvalid at N+1 (with out.tready held high).
- Payload latency is 1 cycle input to output. Throughput is one flit per cycle.
- In IDLE, in.tready=0. Payload presented early stalls and is not lost.
- Back-to-back packets: req_ready rises in the cycle after the last flit is loaded. Minimum packet gap on out is one idle cycle.
- req_valid arriving while busy is held off (req_ready=0).
- Reset asserted mid-packet: the partial packet is dropped and all outputs return to reset values immediately. The router must be reset alongside.
- Simultaneous output drain and input load in the same cycle: permitted, no bubble.

## Configuration
- NOC_PACKETIZER_SRC_HDR_EN defined: source X/Y fields are filled from router_X/router_Y.
- NOC_PACKETIZER_SRC_HDR_EN undefined: source fields are 0. Header layout and field offsets are unchanged.

## Structure
- Shared package noc_pkg:
  - header field offset constants.
  - LEN_W function of MAX_PACKAGES.
  - packed typedef noc_header_t (dest_x, dest_y, src_x, src_y, len).
  - FSM state enum.
- One natural sub-module, axis_out_slice: a single-entry registered output stage with the hold-on-stall rule. It is reusable on router outputs.

## Test plan
- CS=2, router (1,1): req dest (3,0), len 2, payloads 0xA, 0xB, out.tready=1 → flits: header with dest X=3, dest Y=0, src (1,1), len=2, tlast=0; then 0xA (tlast=0); then 0xB (tlast=1). Header appears 1 cycle after the request handshake.
- req len 0 to (0,0) → single header flit with tlast=1; in.tready stays 0 throughout.
- req len 7 with MAX_PACKAGES=4 → header len=4, exactly 4 payload flits, last one tlast=1; len_err=1 and it stays set.
- Random out.tready stalls during a 4-flit packet → tdata/tlast stable while stalled, no flit lost or duplicated, order preserved.
- rst pulsed after the 1st payload flit → out.tvalid=0 in the same cycle, state IDLE; a new request then produces a clean packet.
- Macro undefined → source fields of the header read 0 for router (2,3).

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: header field offsets, length width, header struct, packetizer FSM states.
// Offsets are functions of the coordinate width so one package serves any CS.
// noc_header_t is laid out for the default CS=2 / MAX_PACKAGES=4 build.
package noc_pkg;

  // Width of a length field able to hold 0..max_packages
  function automatic int len_w(input int max_packages);
    return $clog2(max_packages) + 1;
  endfunction

  // Header field offsets (LSB position) for coordinate width cs
  function automatic int off_dest_x(input int cs);
    return 0;
  endfunction

  function automatic int off_dest_y(input int cs);
    return cs;
  endfunction

  function automatic int off_src_x(input int cs);
    return 2 * cs;
  endfunction

  function automatic int off_src_y(input int cs);
    return 3 * cs;
  endfunction

  function automatic int off_len(input int cs);
    return 4 * cs;
  endfunction

  localparam int NOC_CS    = 2;
  localparam int NOC_MAX   = 4;
  localparam int NOC_LEN_W = len_w(NOC_MAX);

  // Declared MSB first so dest_x lands in the lowest bits
  typedef struct packed {
    logic [NOC_LEN_W-1:0] len;
    logic [NOC_CS-1:0]    src_y;
    logic [NOC_CS-1:0]    src_x;
    logic [NOC_CS-1:0]    dest_y;
    logic [NOC_CS-1:0]    dest_x;
  } noc_header_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } noc_state_t;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle between core, packetizer and router.
// m drives data/valid/last, s drives ready.
// tlast is not part of the slave view: the packetizer ignores payload framing.
interface axis_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport m (output tdata, output tvalid, output tlast, input tready);
  modport s (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_out_slice.sv
// Single-entry registered output stage for a stream.
// Latency: 1 cycle from load to valid on the output.
// Backpressure: holds data/last stable while valid & !ready; ready to load when empty or draining.
module axis_out_slice #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready
);

  // Free when empty or the current flit leaves this cycle (drain and refill without a bubble)
  assign load_ready = !out_valid || out_ready;

  // Output register: update only when free, otherwise hold the stalled flit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load_ready) begin
      out_valid <= load_valid;
      if (load_valid) begin
        out_data <= load_data;
        out_last <= load_last;
      end
    end
  end

endmodule

// File: rtl/noc_packetizer.sv
// Core-side NoC transmitter: request + payload stream -> header flit then payload flits, tlast on final.
// Latency: header 1 cycle after entering HEADER, payload 1 cycle input to output, 1 flit/cycle.
// Backpressure: out stall holds the output register and drops in.tready; optional macro NOC_PACKETIZER_SRC_HDR_EN.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CS           = 2,
  parameter int MAX_PACKAGES = 4,
  parameter int router_X     = 0,
  parameter int router_Y     = 0,
  localparam int LEN_W       = len_w(MAX_PACKAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CS-1:0]    req_dest_x,
  input  logic [CS-1:0]    req_dest_y,
  input  logic [LEN_W-1:0] req_len,
  output logic             len_err,
  axis_if.s                in,
  axis_if.m                out
);

  localparam int OFF_DX  = off_dest_x(CS);
  localparam int OFF_DY  = off_dest_y(CS);
  localparam int OFF_SX  = off_src_x(CS);
  localparam int OFF_SY  = off_src_y(CS);
  localparam int OFF_LEN = off_len(CS);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_PACKAGES);

`ifdef NOC_PACKETIZER_SRC_HDR_EN
  localparam logic [CS-1:0] SRC_X = CS'(router_X);
  localparam logic [CS-1:0] SRC_Y = CS'(router_Y);
`else
  localparam logic [CS-1:0] SRC_X = '0;
  localparam logic [CS-1:0] SRC_Y = '0;
`endif

  noc_state_t state, state_nxt;

  logic [CS-1:0]         dest_x, dest_y;
  logic [LEN_W-1:0]      len, remaining;
  logic [DATA_WIDTH-1:0] header;
  logic                  req_fire;
  logic                  in_ready;
  logic                  in_fire;
  logic                  slice_ready;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;

  assign req_fire = req_valid && req_ready;
  assign in_fire  = in.tvalid && in_ready;
  assign in.tready = in_ready;

  // Assemble the header word from the latched request; unused bits stay 0
  always_comb begin
    header = '0;
    header[OFF_DX +: CS]     = dest_x;
    header[OFF_DY +: CS]     = dest_y;
    header[OFF_SX +: CS]     = SRC_X;
    header[OFF_SY +: CS]     = SRC_Y;
    header[OFF_LEN +: LEN_W] = len;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshakes and output-stage load control
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    in_ready   = 1'b0;
    load_valid = 1'b0;
    load_data  = header;
    load_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gated by rst so the request side looks busy throughout reset
        req_ready = !rst;
        if (req_valid && !rst) state_nxt = ST_HEADER;
      end
      ST_HEADER: begin
        if (slice_ready) begin
          load_valid = 1'b1;
          load_last  = (len == '0);
          state_nxt  = (len == '0) ? ST_IDLE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        in_ready  = slice_ready;
        load_data = in.tdata;
        load_last = (remaining <= LEN_W'(1));
        if (in.tvalid && slice_ready) begin
          load_valid = 1'b1;
          if (remaining <= LEN_W'(1)) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch (length clamped to MAX_PACKAGES), sticky error and remaining-flit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_x    <= '0;
      dest_y    <= '0;
      len       <= '0;
      remaining <= '0;
      len_err   <= 1'b0;
    end else begin
      if (req_fire) begin
        dest_x <= req_dest_x;
        dest_y <= req_dest_y;
        if (req_len > LEN_MAX) begin
          len     <= LEN_MAX;
          len_err <= 1'b1;
        end else begin
          len <= req_len;
        end
      end
      if (state == ST_HEADER && slice_ready) begin
        remaining <= len;
      end else if (in_fire && remaining != '0) begin
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  axis_out_slice #(.DATA_WIDTH(DATA_WIDTH)) u_out_slice (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (slice_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .out_data   (out.tdata),
    .out_valid  (out.tvalid),
    .out_last   (out.tlast),
    .out_ready  (out.tready)
  );

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer with a flit scoreboard and stall-stability monitor.
// Router at (2,3); source header fields expected only when NOC_PACKETIZER_SRC_HDR_EN is defined.
// Inputs driven away from the rising edge, outputs sampled on the falling edge.
module tb_noc_packetizer;
  import noc_pkg::*;

  localparam int DW  = 32;
  localparam int CSW = 2;
  localparam int MAXP = 4;
  localparam int LW  = len_w(MAXP);
  localparam int RX  = 2;
  localparam int RY  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [CSW-1:0] req_dest_x = '0;
  logic [CSW-1:0] req_dest_y = '0;
  logic [LW-1:0]  req_len = '0;
  logic           len_err;
  logic           rand_mode = 1'b0;

  axis_if #(.DATA_WIDTH(DW)) in_if ();
  axis_if #(.DATA_WIDTH(DW)) out_if ();

  noc_packetizer #(
    .DATA_WIDTH(DW), .CS(CSW), .MAX_PACKAGES(MAXP), .router_X(RX), .router_Y(RY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dest_x (req_dest_x),
    .req_dest_y (req_dest_y),
    .req_len    (req_len),
    .len_err    (len_err),
    .in         (in_if),
    .out        (out_if)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } flit_t;

  flit_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] exp_hdr(input logic [CSW-1:0] x, input logic [CSW-1:0] y,
                                              input logic [LW-1:0] l);
    noc_header_t h;
    logic [DW-1:0] w;
    h.dest_x = x;
    h.dest_y = y;
`ifdef NOC_PACKETIZER_SRC_HDR_EN
    h.src_x  = CSW'(RX);
    h.src_y  = CSW'(RY);
`else
    h.src_x  = '0;
    h.src_y  = '0;
`endif
    h.len    = l;
    w = '0;
    w[$bits(noc_header_t)-1:0] = h;
    return w;
  endfunction

  // Output ready: always 1, or random while rand_mode is set
  always @(posedge clk) begin
    #1 out_if.tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard and hold-on-stall monitor
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    flit_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_if.tvalid), 64'd1);
        check("stall_data",  64'(out_if.tdata), 64'(prev_data));
        check("stall_last",  64'(out_if.tlast), 64'(prev_last));
      end
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_data  = out_if.tdata;
      prev_last  = out_if.tlast;
      if (out_if.tvalid && out_if.tready) begin
        if (sb.size() == 0) begin
          check("unexpected_flit", 64'(out_if.tdata), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("flit_data", 64'(out_if.tdata), 64'(e.data));
          check("flit_last", 64'(out_if.tlast), 64'(e.last));
        end
      end
    end
  end

  // Issue a request and return just after the accepting edge; expected header goes to the scoreboard
  task automatic do_req(input logic [CSW-1:0] x, input logic [CSW-1:0] y, input logic [LW-1:0] l);
    logic [LW-1:0] eff;
    bit ok;
    eff = (l > LW'(MAXP)) ? LW'(MAXP) : l;
    sb.push_back({exp_hdr(x, y, eff), (eff == '0)});
    @(negedge clk);
    req_valid = 1'b1; req_dest_x = x; req_dest_y = y; req_len = l;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("req_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Present one payload flit and return just after it is accepted
  task automatic send_payload(input logic [DW-1:0] d, input logic last);
    bit ok;
    sb.push_back({d, last});
    @(negedge clk);
    in_if.tvalid = 1'b1; in_if.tdata = d;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (in_if.tready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("payload_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 in_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    out_if.tready = 1'b1;

    // Reset values
    @(negedge clk);
    check("rst_tvalid",    64'(out_if.tvalid), 64'd0);
    check("rst_tdata",     64'(out_if.tdata),  64'd0);
    check("rst_tlast",     64'(out_if.tlast),  64'd0);
    check("rst_in_tready", 64'(in_if.tready),  64'd0);
    check("rst_req_ready", 64'(req_ready),     64'd0);
    check("rst_len_err",   64'(len_err),       64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'd1);

    // Packet to (3,0) len 2: header latency, payload latency, tlast, ready after last load
    do_req(2'd3, 2'd0, 3'd2);
    @(negedge clk);
    check("hdr_not_yet", 64'(out_if.tvalid), 64'd0);
    @(negedge clk);
    check("hdr_valid", 64'(out_if.tvalid), 64'd1);
    check("hdr_word",  64'(out_if.tdata),  64'(exp_hdr(2'd3, 2'd0, 3'd2)));
    send_payload(32'hA, 1'b0);
    @(negedge clk);
    check("pay_a_latency", 64'(out_if.tdata), 64'hA);
    send_payload(32'hB, 1'b1);
    @(negedge clk);
    check("pay_b_last",  64'(out_if.tlast), 64'd1);
    check("b2b_req_rdy", 64'(req_ready),    64'd1);
    drain();

    // Zero-length packet: header only with tlast, no payload accepted
    do_req(2'd0, 2'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("len0_in_tready", 64'(in_if.tready), 64'd0);
    end
    drain();
    check("len0_no_err", 64'(len_err), 64'd0);

    // Early payload must stall in IDLE, then flow after the request; length 7 clamps to 4
    @(negedge clk);
    in_if.tvalid = 1'b1; in_if.tdata = 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("early_stalled", 64'(in_if.tready), 64'd0);
    end
    do_req(2'd1, 2'd2, 3'd7);
    check("len_err_set", 64'(len_err), 64'd1);
    for (int i = 0; i < 4; i++) send_payload(32'h100 + 32'(i), i == 3);
    @(negedge clk);
    check("clamp_done_in_tready", 64'(in_if.tready), 64'd0);
    drain();
    check("len_err_sticky", 64'(len_err), 64'd1);

    // Random output stalls across a 4-flit packet
    rand_mode = 1'b1;
    do_req(2'd2, 2'd1, 3'd4);
    for (int i = 0; i < 4; i++) send_payload(32'hC0DE_0000 + 32'(i), i == 3);
    drain();
    rand_mode = 1'b0;

    // Mid-packet reset after the first payload flit has left
    do_req(2'd1, 2'd3, 3'd2);
    send_payload(32'h55, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_tvalid",    64'(out_if.tvalid), 64'd0);
    check("mid_rst_in_tready", 64'(in_if.tready),  64'd0);
    check("mid_rst_req_ready", 64'(req_ready),     64'd0);
    check("mid_rst_len_err",   64'(len_err),       64'd0);
    check("mid_rst_sb",        64'(sb.size()),     64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 64'(req_ready), 64'd1);

    // Clean packet after reset; source fields follow the build option
    do_req(2'd3, 2'd3, 3'd1);
    @(negedge clk);
    @(negedge clk);
`ifdef NOC_PACKETIZER_SRC_HDR_EN
    check("src_fields", 64'(out_if.tdata[4*CSW-1:2*CSW]), 64'({2'(RY), 2'(RX)}));
`else
    check("src_fields", 64'(out_if.tdata[4*CSW-1:2*CSW]), 64'd0);
`endif
    send_payload(32'h77, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
